// File: rtl/dram_stream_pkg.sv
// Shared state encoding, CSR map and control/status bit positions for the DRAM stream reader.
package dram_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] CSR_ADDR_INIT = 2'd0;
  localparam logic [1:0] CSR_LENGTH    = 2'd1;
  localparam logic [1:0] CSR_STEP      = 2'd2;
  localparam logic [1:0] CSR_CTRL      = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_LOOP  = 2;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_OVF  = 2;
  localparam int STAT_LOOP = 3;

endpackage

// File: rtl/stream_fifo.sv
// Synchronous FIFO holding returned DDR samples; head is forced to zero while empty.
module stream_fifo
  import dram_stream_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic signed [DATA_W-1:0] push_data,
  input  logic                     pop,
  output logic signed [DATA_W-1:0] head,
  output logic                     empty,
  output logic                     full,
  output logic [CNT_W-1:0]         count
);

  localparam int PTR_W = CNT_W - 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic signed [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic wr_en, rd_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);
  assign count = count_q;
  assign head  = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    rd_en    = pop && !empty;
    wr_en    = push && (!full || rd_en);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_en    = 1'b0;
      wr_en    = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/dram_stream_reader.sv
// CSR-programmed strided DDR reader streaming samples out through a credit-limited FIFO.
// Optional build macro DRAM_STREAM_LOOP_EN adds control bit2 (loop) and status bit3.
module dram_stream_reader
  import dram_stream_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [ADDR_W-1:0]        ddr_addr,
  output logic                     ddr_read,
  input  logic                     ddr_waitrequest,
  input  logic signed [DATA_W-1:0] ddr_readdata,
  input  logic                     ddr_readdatavalid,
  input  logic [1:0]               addr,
  input  logic                     read,
  input  logic                     write,
  input  logic [31:0]              writedata,
  output logic [31:0]              readdata,
  output logic signed [DATA_W-1:0] d_out,
  output logic                     vout,
  input  logic                     rdy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] CREDIT_C = (CNT_W + 1)'(FIFO_DEPTH);

  state_e state_q, state_d;
  logic [ADDR_W-1:0] ddr_addr_q, ddr_addr_d, addr_init_q, addr_init_d, addr_step_q, addr_step_d;
  logic [31:0] len_q, len_d, issued_q, issued_d, readdata_q, readdata_d, status;
  logic [CNT_W-1:0] outst_q, outst_d, fifo_count;
  logic ovf_q, ovf_d, abort_q, abort_d;
  logic busy, ctrl_wr, start, abort, credit_ok, accept, rsp, push, pop;
  logic fifo_flush, fifo_empty, fifo_full, ovf_hit, loop_on;

  assign busy      = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign ctrl_wr   = write && (addr == CSR_CTRL);
  assign start     = ctrl_wr && writedata[CTRL_START];
  assign abort     = ctrl_wr && writedata[CTRL_ABORT];
  // Outstanding reads plus buffered samples may never exceed the buffer, so every return has a slot.
  assign credit_ok = ({1'b0, outst_q} + {1'b0, fifo_count}) < CREDIT_C;
  assign ddr_read  = (state_q == ST_ISSUE) && (issued_q < len_q) && credit_ok;
  assign accept    = ddr_read && !ddr_waitrequest;
  assign rsp       = ddr_readdatavalid && (outst_q != '0);
  assign push      = rsp && busy && !abort_q;
  assign pop       = vout && rdy;
  assign fifo_flush = busy && abort;
  assign ovf_hit   = push && fifo_full && !pop;
  assign vout      = !fifo_empty;
  assign ddr_addr  = ddr_addr_q;
  assign readdata  = readdata_q;

`ifdef DRAM_STREAM_LOOP_EN
  logic loop_q, loop_d;
  assign loop_on = loop_q;

  always_comb begin
    loop_d = loop_q;
    if (start && !busy) loop_d = writedata[CTRL_LOOP];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) loop_q <= 1'b0;
    else        loop_q <= loop_d;
  end
`else
  assign loop_on = 1'b0;
`endif

  always_comb begin
    status            = '0;
    status[STAT_BUSY] = busy;
    status[STAT_DONE] = (state_q == ST_DONE);
    status[STAT_OVF]  = ovf_q;
    status[STAT_LOOP] = loop_on;
  end

  always_comb begin
    state_d     = state_q;
    ddr_addr_d  = ddr_addr_q;
    addr_init_d = addr_init_q;
    addr_step_d = addr_step_q;
    len_d       = len_q;
    issued_d    = issued_q;
    outst_d     = outst_q;
    ovf_d       = ovf_q;
    abort_d     = abort_q;
    readdata_d  = readdata_q;

    if (write && !busy) begin
      case (addr)
        CSR_ADDR_INIT: addr_init_d = ADDR_W'(writedata);
        CSR_LENGTH:    len_d       = writedata;
        CSR_STEP:      addr_step_d = ADDR_W'(writedata);
        default:       ;
      endcase
    end

    if (read) begin
      case (addr)
        CSR_ADDR_INIT: readdata_d = 32'(addr_init_q);
        CSR_LENGTH:    readdata_d = len_q;
        CSR_STEP:      readdata_d = 32'(addr_step_q);
        default:       readdata_d = status;
      endcase
    end

    if (accept) begin
      issued_d   = issued_q + 32'd1;
      ddr_addr_d = ddr_addr_q + addr_step_q;
    end

    case ({accept, rsp})
      2'b10:   outst_d = outst_q + CNT_W'(1);
      2'b01:   outst_d = outst_q - CNT_W'(1);
      default: outst_d = outst_q;
    endcase

    if (ovf_hit) ovf_d = 1'b1;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          ddr_addr_d = addr_init_q;
          issued_d   = '0;
          outst_d    = '0;
          ovf_d      = 1'b0;
          abort_d    = 1'b0;
          state_d    = (len_q == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (abort) begin
          abort_d = 1'b1;
          state_d = ST_DRAIN;
        end else if (issued_q == len_q) begin
          if (loop_on) begin
            ddr_addr_d = addr_init_q;
            issued_d   = '0;
          end else begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // While aborting, returns are counted off but never buffered.
        if (abort) abort_d = 1'b1;
        else if ((outst_q == '0) && fifo_empty) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ddr_addr_q  <= '0;
      addr_init_q <= '0;
      addr_step_q <= ADDR_W'(1);
      len_q       <= '0;
      issued_q    <= '0;
      outst_q     <= '0;
      ovf_q       <= 1'b0;
      abort_q     <= 1'b0;
      readdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      ddr_addr_q  <= ddr_addr_d;
      addr_init_q <= addr_init_d;
      addr_step_q <= addr_step_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      outst_q     <= outst_d;
      ovf_q       <= ovf_d;
      abort_q     <= abort_d;
      readdata_q  <= readdata_d;
    end
  end

  stream_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (fifo_flush),
    .push      (push),
    .push_data (ddr_readdata),
    .pop       (pop),
    .head      (d_out),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

endmodule

// File: doc/dram_stream_reader.md
DRAM_STREAM_READER -- requirements
Module: dram_stream_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample/DDR read-data width.
REQ-002 SHALL have parameter ADDR_W, default 32, DDR address width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, power of two, output buffer entries.
REQ-004 SHALL have ports: clk in 1 clock; rst_n in 1 reset, synchronous and active-low.
REQ-005 SHALL have DDR master ports: ddr_addr out ADDR_W; ddr_read out 1; ddr_waitrequest in 1; ddr_readdata in DATA_W signed; ddr_readdatavalid in 1.
REQ-006 SHALL have CSR slave ports: addr in 2; read in 1; write in 1; writedata in 32; readdata out 32.
REQ-007 SHALL have stream ports: d_out out DATA_W signed; vout out 1; rdy in 1 (sink ready).

Function
REQ-008 CSR map: 0 addr_init; 1 stream_length (samples); 2 addr_step; 3 control (write) / status (read).
REQ-009 Control write bits: bit0 start, bit1 abort; status read = {29'b0, fifo_overflow_sticky, done, busy}.
REQ-010 readdata SHALL be registered, valid one cycle after read; unmapped bits zero.
REQ-011 Writes to CSR 0-2 while busy SHALL be ignored; start while busy ignored.
REQ-012 States: IDLE, ISSUE, DRAIN, DONE; busy=1 in ISSUE/DRAIN, done=1 in DONE.
REQ-013 IDLE->ISSUE on start; ddr_addr loads addr_init, issued and received counts clear; stream_length==0 goes IDLE->DONE directly.
REQ-014 ISSUE: ddr_read asserted only while issued<stream_length and outstanding+fifo_count<FIFO_DEPTH (credit rule).
REQ-015 Read accepted when ddr_read && !ddr_waitrequest; ddr_addr SHALL then advance by addr_step (modulo 2^ADDR_W); ddr_addr/ddr_read held stable while waitrequest=1.
REQ-016 ISSUE->DRAIN when issued==stream_length; DRAIN->DONE when outstanding==0 and FIFO empty and last sample consumed.
REQ-017 Each ddr_readdatavalid SHALL push ddr_readdata into FIFO; outstanding SHALL never exceed FIFO_DEPTH.
REQ-018 Push into full FIFO SHALL not corrupt data; sample dropped, fifo_overflow_sticky set until next start.
REQ-019 Output: vout=1 while FIFO non-empty; d_out=FIFO head; pop on vout&&rdy; first sample appears 1 cycle after its readdatavalid.
REQ-020 Simultaneous push and pop SHALL keep fifo_count unchanged.
REQ-021 Abort in ISSUE/DRAIN: stop issuing next cycle, flush FIFO, discard returning data until outstanding==0, then DONE.
REQ-022 DONE->IDLE on next start write (immediately re-entering ISSUE per REQ-013).

Reset
REQ-023 rst_n=0 at any clock edge: state IDLE, ddr_read=0, ddr_addr=0, vout=0, d_out=0, readdata=0, addr_init=0, stream_length=0, addr_step=1, counters and sticky flag 0, FIFO empty.
REQ-024 Reset mid-burst SHALL drop all outstanding reads; data returning afterward ignored until a new start.

Configuration
REQ-025 Macro DRAM_STREAM_LOOP_EN: when defined, control bit2 loop; with loop=1, ISSUE at issued==stream_length reloads ddr_addr=addr_init and clears issued, never entering DRAIN until abort; status bit3 reports loop.
REQ-026 Without DRAM_STREAM_LOOP_EN, bit2 ignored, status bit3 reads 0, behaviour per REQ-016.

Structure
REQ-027 Package dram_stream_pkg SHALL hold state enum, CSR address constants, control/status bit positions.
REQ-028 Sub-module stream_fifo (synchronous FIFO, DATA_W x FIFO_DEPTH, count output) SHALL be instantiated once.

Verification
REQ-029 addr_init=0x100, step=2, length=4, rdy=1, zero-wait DDR -> reads at 0x100,0x102,0x104,0x106; four samples out in order; done=1.
REQ-030 waitrequest=1 for 3 cycles on 2nd read -> ddr_addr 0x102 held 3 cycles; no duplicate or lost sample.
REQ-031 rdy=0 throughout, length=40, FIFO_DEPTH=16 -> exactly 16 reads issued, then ddr_read=0; releasing rdy completes all 40.
REQ-032 length=0 start -> status=0b010 next cycle, no ddr_read.
REQ-033 abort after 5 of 20 reads with 3 outstanding -> vout drops, 3 returns discarded, done=1, no further reads.
REQ-034 rst_n=0 mid-ISSUE -> all outputs at reset values next edge; late readdatavalid produces no vout.
